de1_video_timing: RTL and testbench

DE1_VIDEO_TIMING -- requirements
Module: de1_video_timing

---
 rtl/de1_video_timing_pkg.sv | 59 +++++
 rtl/de1_video_timing_axis.sv | 48 ++++
 rtl/de1_video_timing.sv | 204 ++++++++++++++++++++
 tb/tb_de1_video_timing.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/de1_video_timing_pkg.sv
// ---------------------------------------------------------------------------
// de1_video_timing_pkg
// Shared types and constants for the DE1 video timing generator.
//   state_t    : controller states (idle / generating frames)
//   coord_t    : 12-bit pixel/line coordinate
//   rgb_t      : 24-bit colour, {r, g, b}
//   LCD_* / VGA_* : timing sets for a 480x272 LCD panel and 640x480 VGA
//   colour_bar : 8-band colour bar generator used by the optional test pattern
// ---------------------------------------------------------------------------
package de1_video_timing_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef logic [11:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Largest total that a 12-bit counter can still reach
    localparam int COORD_MAX = 4095;

    // 480x272 LCD panel
    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BP     = 2;
    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BP     = 2;

    // 640x480 VGA, 800x525 total
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Band index is x*8/h_active; each band bit drives one full colour channel
    function automatic rgb_t colour_bar(input coord_t x, input int h_active);
        logic [2:0] band;
        rgb_t       c;
        band = 3'((int'(x) * 8) / h_active);
        c.r  = {8{band[2]}};
        c.g  = {8{band[1]}};
        c.b  = {8{band[0]}};
        return c;
    endfunction

endpackage

// File: rtl/de1_video_timing_axis.sv
// ---------------------------------------------------------------------------
// de1_video_timing_axis
// One timing axis: a wrapping counter 0..TOTAL-1 with region decode.
// Used once for pixels within a line and once for lines within a frame.
//   clk, reset_n : clock, asynchronous active-low reset
//   advance      : count one step this cycle (wraps after TOTAL-1)
//   count        : current position on the axis
//   active       : position is inside the visible region
//   in_sync      : position is inside the sync pulse
//   last         : position is TOTAL-1 (the next step wraps)
// ---------------------------------------------------------------------------
module de1_video_timing_axis
    import de1_video_timing_pkg::*;
#(
    parameter int ACTIVE = LCD_H_ACTIVE,
    parameter int FP     = LCD_H_FP,
    parameter int SYNC   = LCD_H_SYNC,
    parameter int BP     = LCD_H_BP
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   advance,
    output coord_t count,
    output logic   active,
    output logic   in_sync,
    output logic   last
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST_C     = coord_t'(TOTAL - 1);
    localparam coord_t ACTIVE_C   = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (advance) begin
            count <= last ? '0 : count + 12'd1;
        end
    end

    // Regions run active, front porch, sync, back porch
    assign last    = (count == LAST_C);
    assign active  = (count < ACTIVE_C);
    assign in_sync = (count >= SYNC_START) && (count < SYNC_END);

endmodule

// File: rtl/de1_video_timing.sv
// ---------------------------------------------------------------------------
// de1_video_timing
// Video timing generator for the DE1 VGA DAC / LCD. Requests pixels by
// coordinate, takes the colour back one cycle later and drives the sync,
// blank and colour outputs aligned two cycles after the request.
//   clk, reset_n     : pixel clock, asynchronous active-low reset
//   run              : keep generating frames (checked at each frame end)
//   pixel_req, x, y  : fetch strobe and coordinate of the pixel wanted
//   pixel_data       : {r,g,b} for the request made one cycle earlier
//   frame_start      : pulse in the h=0, v=0 cycle
//   line_start       : pulse in every h=0 cycle
//   vga_hs, vga_vs   : syncs (level HS_POL / VS_POL while in sync)
//   vga_blank_n      : high on visible pixels
//   vga_sync_n       : tied low
//   vga_red/green/blue : colour, forced to 0 while blanked
//   busy             : a frame is in progress
// Build option: DE1_VIDEO_TIMING_TEST_PATTERN_EN adds input switches[9],
// which replaces pixel_data with internal 8-band colour bars.
// ---------------------------------------------------------------------------
module de1_video_timing
    import de1_video_timing_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic        pixel_req,
    output logic [11:0] x,
    output logic [11:0] y,
    input  logic [23:0] pixel_data,
`ifdef DE1_VIDEO_TIMING_TEST_PATTERN_EN
    input  logic [9:9]  switches,
`endif
    output logic        frame_start,
    output logic        line_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_red,
    output logic [7:0]  vga_green,
    output logic [7:0]  vga_blue,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_check
        $error("de1_video_timing: H/V totals must fit a 12-bit counter");
    end

    state_t state;
    state_t state_next;
    logic   in_run;
    coord_t h_count;
    coord_t v_count;
    logic   h_active;
    logic   h_sync;
    logic   h_last;
    logic   v_active;
    logic   v_sync;
    logic   v_last;
    coord_t x_hold;
    coord_t y_hold;
    logic   blank_d1;
    logic   hs_d1;
    logic   vs_d1;
    rgb_t   colour_src;
    rgb_t   colour_q;

    assign in_run = (state == ST_RUN);
    assign busy   = in_run;

    de1_video_timing_axis #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (in_run),
        .count   (h_count),
        .active  (h_active),
        .in_sync (h_sync),
        .last    (h_last)
    );

    // Lines advance on the last pixel of each line
    de1_video_timing_axis #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (in_run && h_last),
        .count   (v_count),
        .active  (v_active),
        .in_sync (v_sync),
        .last    (v_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving RUN only happens on the final wrap, so the counters are
    // already back at 0,0 whenever the block sits in IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (run) state_next = ST_RUN;
            ST_RUN:  if (h_last && v_last && !run) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign pixel_req   = in_run && h_active && v_active;
    assign frame_start = in_run && (h_count == '0) && (v_count == '0);
    assign line_start  = in_run && (h_count == '0);

    // x/y follow the counters on requests and otherwise keep the last request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_hold <= '0;
            y_hold <= '0;
        end else if (pixel_req) begin
            x_hold <= h_count;
            y_hold <= v_count;
        end
    end

    assign x = pixel_req ? h_count : x_hold;
    assign y = pixel_req ? v_count : y_hold;

    // First delay stage: controls wait here while the pixel is fetched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_d1 <= 1'b0;
            hs_d1    <= ~HS_POL;
            vs_d1    <= ~VS_POL;
        end else begin
            blank_d1 <= pixel_req;
            hs_d1    <= (in_run && h_sync) ? HS_POL : ~HS_POL;
            vs_d1    <= (in_run && v_sync) ? VS_POL : ~VS_POL;
        end
    end

`ifdef DE1_VIDEO_TIMING_TEST_PATTERN_EN
    rgb_t bar_d1;

    // Colour bars are computed from the request coordinate and delayed one
    // stage so they meet the output register in step with pixel_data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bar_d1 <= '0;
        end else begin
            bar_d1 <= colour_bar(x, H_ACTIVE);
        end
    end

    assign colour_src = switches[9] ? bar_d1 : rgb_t'(pixel_data);
`else
    assign colour_src = rgb_t'(pixel_data);
`endif

    // Second stage: capture the returned colour next to its aligned controls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_blank_n <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            colour_q    <= '0;
        end else begin
            vga_blank_n <= blank_d1;
            vga_hs      <= hs_d1;
            vga_vs      <= vs_d1;
            colour_q    <= blank_d1 ? colour_src : '0;
        end
    end

    assign vga_red    = colour_q.r;
    assign vga_green  = colour_q.g;
    assign vga_blue   = colour_q.b;
    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_de1_video_timing.sv
// ---------------------------------------------------------------------------
// tb_de1_video_timing
// Bench for de1_video_timing using a reduced 23x10 timing so whole frames
// run quickly. A frame-position model predicts every output each cycle;
// directed sections pin frame length, sync widths, pixel latency, run
// drop/reassert, mid-frame reset and (in the pattern build) colour bars.
// Build option: DE1_VIDEO_TIMING_TEST_PATTERN_EN enables the bar checks.
// ---------------------------------------------------------------------------
module tb_de1_video_timing;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam bit HPOL = 1'b0;
    localparam bit VPOL = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        run = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        pixel_req;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;
    logic        line_start;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic [7:0]  vga_red;
    logic [7:0]  vga_green;
    logic [7:0]  vga_blue;
    logic        busy;
`ifdef DE1_VIDEO_TIMING_TEST_PATTERN_EN
    logic [9:9]  switches = '0;
`endif

    int n_compared = 0;
    int n_mismatched = 0;
    bit sw_model = 1'b0;

    always #5 clk = ~clk;

    de1_video_timing #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL (HPOL), .VS_POL (VPOL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .pixel_req   (pixel_req),
        .x           (x),
        .y           (y),
        .pixel_data  (pixel_data),
`ifdef DE1_VIDEO_TIMING_TEST_PATTERN_EN
        .switches    (switches),
`endif
        .frame_start (frame_start),
        .line_start  (line_start),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .vga_red     (vga_red),
        .vga_green   (vga_green),
        .vga_blue    (vga_blue),
        .busy        (busy)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read there too
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [23:0] bar_colour(input int h);
        int band;
        band = (h * 8) / HA;
        return {((band & 4) != 0) ? 8'hFF : 8'h00,
                ((band & 2) != 0) ? 8'hFF : 8'h00,
                ((band & 1) != 0) ? 8'hFF : 8'h00};
    endfunction

    // Pixel source behaves like a synchronous memory: data for a request
    // appears for the following cycle; otherwise random junk is presented
    initial begin : pixel_source
        logic        req_s;
        logic [11:0] x_s;
        logic [11:0] y_s;
        forever begin
            @(negedge clk);
            req_s = pixel_req;
            x_s   = x;
            y_s   = y;
            @(posedge clk);
            #1;
            pixel_data = req_s ? {y_s[7:0], x_s[7:0], 8'h5A} : 24'($urandom);
        end
    end

    // Model: the frame is a single position 0..FRAME-1; h and v are derived
    // from it, and the aligned VGA outputs are the raw values of two cycles ago
    bit          m_running;
    int          m_pos;
    int          m_last_x;
    int          m_last_y;
    int          m_h;
    int          m_v;
    int          m_x;
    int          m_y;
    bit          m_req;
    bit          raw_hs;
    bit          raw_vs;
    logic [23:0] raw_rgb;
    bit          hist_blank [2];
    bit          hist_hs [2];
    bit          hist_vs [2];
    logic [23:0] hist_rgb [2];

    task automatic model_reset();
        m_running = 1'b0;
        m_pos     = 0;
        m_last_x  = 0;
        m_last_y  = 0;
        for (int i = 0; i < 2; i++) begin
            hist_blank[i] = 1'b0;
            hist_hs[i]    = !HPOL;
            hist_vs[i]    = !VPOL;
            hist_rgb[i]   = '0;
        end
    endtask

    initial begin : model_compare
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            m_h   = m_pos % HT;
            m_v   = m_pos / HT;
            m_req = m_running && (m_h < HA) && (m_v < VA);
            m_x   = m_req ? m_h : m_last_x;
            m_y   = m_req ? m_v : m_last_y;
            check_output("ctrl {req,x,y,fs,ls,busy}",
                         {4'b0, pixel_req, x, y, frame_start, line_start, busy},
                         {4'b0, m_req, 12'(m_x), 12'(m_y), m_running && (m_pos == 0),
                          m_running && (m_h == 0), m_running});
            check_output("vga {hs,vs,blank_n,sync_n,rgb}",
                         {4'b0, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_red, vga_green, vga_blue},
                         {4'b0, hist_hs[1], hist_vs[1], hist_blank[1], 1'b0, hist_rgb[1]});
            if (reset_n) begin
                raw_hs = (m_running && m_h >= HA + HF && m_h < HA + HF + HS) ? HPOL : !HPOL;
                raw_vs = (m_running && m_v >= VA + VF && m_v < VA + VF + VS) ? VPOL : !VPOL;
                if (!m_req)        raw_rgb = '0;
                else if (sw_model) raw_rgb = bar_colour(m_h);
                else               raw_rgb = {m_v[7:0], m_h[7:0], 8'h5A};
                hist_blank[1] = hist_blank[0];  hist_blank[0] = m_req;
                hist_hs[1]    = hist_hs[0];     hist_hs[0]    = raw_hs;
                hist_vs[1]    = hist_vs[0];     hist_vs[0]    = raw_vs;
                hist_rgb[1]   = hist_rgb[0];    hist_rgb[0]   = raw_rgb;
                if (m_req) begin
                    m_last_x = m_h;
                    m_last_y = m_v;
                end
                if (m_running) begin
                    if (m_pos == FRAME - 1) begin
                        m_pos     = 0;
                        m_running = run;
                    end else begin
                        m_pos++;
                    end
                end else if (run) begin
                    m_running = 1'b1;
                    m_pos     = 0;
                end
            end
        end
    end

    task automatic wait_frame_start(input string name);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 3 * FRAME) begin
            next_cycle();
            n++;
        end
        if (frame_start !== 1'b1) check_output(name, 32'(frame_start), 32'd1);
    endtask

    task automatic wait_pixel(input string name, input int px, input int py);
        int n;
        n = 0;
        while (!(pixel_req === 1'b1 && x == 12'(px) && y == 12'(py)) && n < 3 * FRAME) begin
            next_cycle();
            n++;
        end
        if (pixel_req !== 1'b1) check_output(name, 32'(pixel_req), 32'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit 1000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : apply_stimulus
        int hs_low;
        int vs_on;
        int blank_hi;
        int fs_count;
        int busy_low;

        #1 reset_n = 1'b0;
        repeat (3) next_cycle();
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset hs", 32'(vga_hs), 32'd1);
        check_output("reset vs", 32'(vga_vs), 32'd0);
        check_output("reset blank_n", 32'(vga_blank_n), 32'd0);
        check_output("reset xy", {8'b0, x, y}, 32'd0);

        // Release with run already high: frame starts one cycle after run is seen
        reset_n = 1'b1;
        run     = 1'b1;
        check_output("start fs early", 32'(frame_start), 32'd0);
        next_cycle();
        check_output("start fs", 32'(frame_start), 32'd1);

        // One frame: length and per-frame sync/blank counts
        hs_low = 0; vs_on = 0; blank_hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) check_output("fs inside frame", 32'(frame_start), 32'd0);
            if (vga_hs == 1'b0) hs_low++;
            if (vga_vs == 1'b1) vs_on++;
            if (vga_blank_n == 1'b1) blank_hi++;
            next_cycle();
        end
        check_output("frame period 230", 32'(frame_start), 32'd1);
        check_output("hs low clocks 30", hs_low, 32'd30);
        check_output("vs active clocks 46", vs_on, 32'd46);
        check_output("blank_n high clocks 96", blank_hi, 32'd96);

        // Pixel (10,3) comes out two cycles after its request
        wait_pixel("wait pixel 10,3", 10, 3);
        next_cycle();
        next_cycle();
        check_output("pixel 10,3 rgb", {8'b0, vga_red, vga_green, vga_blue}, 32'h03_0A_5A);
        check_output("pixel 10,3 blank_n", 32'(vga_blank_n), 32'd1);

        // Drop run mid-frame: the frame completes, then nothing more
        wait_frame_start("wait fs before drop");
        for (int i = 1; i < FRAME; i++) begin
            next_cycle();
            if (i == 40) run = 1'b0;
        end
        check_output("busy last cycle", 32'(busy), 32'd1);
        next_cycle();
        check_output("busy after frame", 32'(busy), 32'd0);
        check_output("no fs after drop", 32'(frame_start), 32'd0);
        next_cycle();
        next_cycle();
        check_output("flushed blank_n", 32'(vga_blank_n), 32'd0);
        check_output("flushed hs", 32'(vga_hs), 32'd1);
        fs_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (frame_start === 1'b1) fs_count++;
            next_cycle();
        end
        check_output("idle frame_starts", fs_count, 32'd0);

        // Drop and reassert before the wrap: no gap between frames
        run = 1'b1;
        next_cycle();
        check_output("restart fs", 32'(frame_start), 32'd1);
        busy_low = 0;
        for (int i = 1; i <= FRAME; i++) begin
            next_cycle();
            if (i == 50) run = 1'b0;
            if (i == 200) run = 1'b1;
            if (busy !== 1'b1) busy_low++;
        end
        check_output("no-gap fs", 32'(frame_start), 32'd1);
        check_output("no-gap busy", busy_low, 32'd0);

        // Reset mid-frame: outputs drop at once; restart follows run
        repeat (60) next_cycle();
        reset_n = 1'b0;
        #1;
        check_output("midreset busy/req", {busy, pixel_req}, 32'd0);
        check_output("midreset xy", {8'b0, x, y}, 32'd0);
        check_output("midreset hs/vs/blank", {vga_hs, vga_vs, vga_blank_n}, 32'b100);
        check_output("midreset rgb", {8'b0, vga_red, vga_green, vga_blue}, 32'd0);
        check_output("midreset pulses", {frame_start, line_start}, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        check_output("post-reset fs early", 32'(frame_start), 32'd0);
        next_cycle();
        check_output("post-reset fs", 32'(frame_start), 32'd1);

        // Random run toggling and occasional reset pulses against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) run = !run;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                next_cycle();
                reset_n = 1'b1;
            end
            next_cycle();
        end

`ifdef DE1_VIDEO_TIMING_TEST_PATTERN_EN
        // Colour bars: change the selector only while idle
        run = 1'b0;
        for (int i = 0; i < 3 * FRAME && busy === 1'b1; i++) next_cycle();
        repeat (3) next_cycle();
        switches = 1'b1;
        sw_model = 1'b1;
        run      = 1'b1;
        wait_pixel("wait bar x=0", 0, 0);
        next_cycle();
        next_cycle();
        check_output("bar x=0 black", {8'b0, vga_red, vga_green, vga_blue}, 32'h00_00_00);
        wait_pixel("wait bar x=15", HA - 1, 0);
        next_cycle();
        next_cycle();
        check_output("bar x=15 white", {8'b0, vga_red, vga_green, vga_blue}, 32'hFF_FF_FF);
`endif

        run = 1'b0;
        repeat (5) next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
